// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, grant id width, pointer wrap helper.
// No logic of its own; imported by the picker and the top.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_RD   = 2'd1,
    ARB_WR   = 2'd2
  } arb_state_t;

  localparam int ARB_GID_W = 3;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Round-robin picker: lowest requester at or after i_ptr wins.
// Purely combinational (zero latency); no backpressure of its own.
module mem_port_arbiter_rr_picker
  import mem_port_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [IW-1:0]     w_k;
  logic [IW:0]       w_sum;

  // Rotate so the pointer lands on bit 0, priority-encode, then rotate the index back.
  assign w_dbl = {i_req, i_req};
  assign w_rot = NREQ'(w_dbl >> i_ptr);

  always_comb begin
    w_k = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_k = IW'(i);
    end
  end

  assign w_sum = {1'b0, w_k} + {1'b0, i_ptr};
  assign o_idx = (w_sum >= (IW+1)'(NREQ)) ? IW'(w_sum - (IW+1)'(NREQ)) : w_sum[IW-1:0];
  assign o_any = |i_req;
  assign o_gnt = o_any ? (NREQ'(1) << o_idx) : '0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory read/write port among NREQ engines, one transaction at a time.
// Request at cycle N shows on the memory pins at N+1; requesters wait (hold) until their done pulse.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int AW       = 26,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      q_rvalid,
  input  logic [NREQ*AW-1:0]   q_raddr,
  output logic [NREQ-1:0]      q_rready,
  output logic [DW-1:0]        q_rdata,
  input  logic [NREQ-1:0]      q_wvalid,
  input  logic [NREQ*AW-1:0]   q_waddr,
  input  logic [NREQ*DW-1:0]   q_wdata,
  output logic [NREQ-1:0]      q_wready,
  input  logic [NREQ-1:0]      q_lock,
  output logic                 rvalid,
  output logic [AW-1:0]        raddr,
  input  logic                 rready,
  input  logic [DW-1:0]        rdata,
  output logic                 wvalid,
  output logic [AW-1:0]        waddr,
  output logic [DW-1:0]        wdata,
  input  logic                 wready,
  output logic [ARB_GID_W-1:0] grant_id,
  output logic                 busy,
  output logic                 err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(LOCK_MAX + 1);

  arb_state_t      r_state;
  logic [IW-1:0]   r_own;
  logic [IW-1:0]   r_ptr;
  logic            r_owned;
  logic [CW-1:0]   r_lock_cnt;
  logic            r_rvalid;
  logic            r_wvalid;
  logic [AW-1:0]   r_raddr;
  logic [AW-1:0]   r_waddr;
  logic [DW-1:0]   r_wdata;
  logic            r_err;

  logic [NREQ-1:0] w_req;
  logic [NREQ-1:0] w_pick_gnt;
  logic [IW-1:0]   w_pick_idx;
  logic            w_pick_any;
  logic            w_lock_ok;
  logic [IW-1:0]   w_win;
  logic [NREQ-1:0] w_own_oh;
  logic [NREQ-1:0] w_win_oh;
  logic            w_win_rd;
  logic            w_rd_done;
  logic            w_wr_done;
  logic            w_stray;

  assign w_req = q_rvalid | q_wvalid;

  mem_port_arbiter_rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // A locked owner that is requesting again keeps the port until its streak runs out.
  assign w_lock_ok = r_owned && q_lock[r_own] && w_req[r_own] &&
                     (r_lock_cnt < CW'(LOCK_MAX - 1));
  assign w_own_oh  = NREQ'(1) << r_own;
  assign w_win     = w_lock_ok ? r_own : w_pick_idx;
  assign w_win_oh  = w_lock_ok ? w_own_oh : w_pick_gnt;
  assign w_win_rd  = |(w_win_oh & q_rvalid);

  assign w_rd_done = (r_state == ARB_RD) && rready;
  assign w_wr_done = (r_state == ARB_WR) && wready;
  assign w_stray   = (rready && (r_state != ARB_RD)) || (wready && (r_state != ARB_WR));

  assign q_rready = w_rd_done ? w_own_oh : '0;
  assign q_wready = w_wr_done ? w_own_oh : '0;
  assign q_rdata  = w_rd_done ? rdata : '0;

  assign rvalid   = r_rvalid;
  assign wvalid   = r_wvalid;
  assign raddr    = r_raddr;
  assign waddr    = r_waddr;
  assign wdata    = r_wdata;
  assign err      = r_err;
  assign busy     = (r_state != ARB_IDLE);
  assign grant_id = ARB_GID_W'(r_own);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ARB_IDLE;
      r_own      <= '0;
      r_ptr      <= '0;
      r_owned    <= 1'b0;
      r_lock_cnt <= '0;
      r_rvalid   <= 1'b0;
      r_wvalid   <= 1'b0;
      r_raddr    <= '0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_stray) r_err <= 1'b1;
      case (r_state)
        ARB_IDLE: begin
          if (w_pick_any) begin
            r_own      <= w_win;
            r_owned    <= 1'b1;
            r_ptr      <= IW'(wrap_inc(int'(w_win), NREQ));
            r_lock_cnt <= w_lock_ok ? r_lock_cnt + 1'b1 : '0;
            if (w_win_rd) begin
              r_raddr  <= q_raddr[int'(w_win)*AW +: AW];
              r_rvalid <= 1'b1;
              r_state  <= ARB_RD;
            end else begin
              r_waddr  <= q_waddr[int'(w_win)*AW +: AW];
              r_wdata  <= q_wdata[int'(w_win)*DW +: DW];
              r_wvalid <= 1'b1;
              r_state  <= ARB_WR;
            end
          end
        end
        ARB_RD: begin
          if (rready) begin
            r_rvalid <= 1'b0;
            r_state  <= ARB_IDLE;
          end
        end
        ARB_WR: begin
          if (wready) begin
            r_wvalid <= 1'b0;
            r_state  <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule
